// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO between cmd_parser and uart_tx with a transmit sequencer.
// Buffers response bytes, pops one per UART frame using the uart_tx
// start/ready handshake, and keeps a sticky flag when a write is dropped.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   clr_i            synchronous flush of data and overflow flag
//   wr_en_i/wr_data_i  byte write from cmd_parser
//   full_o/empty_o/count_o  occupancy status from registered count
//   overflow_o       sticky dropped-write flag
//   tx_start_o/tx_data_o   one-cycle start pulse and held byte to uart_tx
//   tx_ready_i       uart_tx idle/ready
module tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [7:0]            wr_data_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  output logic                  tx_start_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_ready_i
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      mem_q [DEPTH];

  logic            full;
  logic            push;
  logic            pop;

  // Status decoded from the registered count only.
  assign full       = (count_q == CW'(DEPTH));
  assign full_o     = full;
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

  // Flush suppresses both a write and a new pop in the same cycle.
  assign push = wr_en_i && !full && !clr_i;
  assign pop  = (state_q == IDLE) && (count_q != '0) && tx_ready_i && !clr_i;

  // Next-state: pointers, count, overflow, output byte and sequencer.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    tx_data_d  = tx_data_q;

    if (clr_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        tx_data_d = mem_q[rd_ptr_q];
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      // A write while full is lost even if a pop frees space this cycle.
      if (wr_en_i && full) begin
        overflow_d = 1'b1;
      end
    end

    // A byte already popped always completes its handshake, even across clr_i.
    unique case (state_q)
      IDLE:      if (pop)          state_d = START;
      START:                       state_d = WAIT_BUSY;
      WAIT_BUSY: if (!tx_ready_i)  state_d = WAIT_DONE;
      WAIT_DONE: if (tx_ready_i)   state_d = IDLE;
      default:                     state_d = IDLE;
    endcase

    tx_start_d = (state_d == START);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule
